// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision serial adder.
package mp_add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int word_cnt_w(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/mp_word_adder.sv
// Combinational 32-bit Brent-Kung adder: up-sweep builds power-of-two group
// generates, down-sweep fills in the remaining prefix carries.
module mp_word_adder
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W-1:0] gen;
  logic [WORD_W-1:0] prop;
  logic [WORD_W-1:0] grp_g;
  logic [WORD_W-1:0] grp_p;
  logic [WORD_W-1:0] carry;

  // Carry-in is folded into bit 0 so every group generate is a true prefix.
  always_comb begin
    gen   = a & b;
    prop  = a ^ b;
    grp_g = gen;
    grp_p = prop;
    grp_g[0] = gen[0] | (prop[0] & cin);
    for (int d = 1; d < WORD_W; d = d * 2) begin
      for (int i = 2 * d - 1; i < WORD_W; i = i + 2 * d) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        grp_p[i] = grp_p[i] & grp_p[i-d];
      end
    end
    for (int d = WORD_W / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < WORD_W; i = i + 2 * d) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
      end
    end
    carry = {grp_g[WORD_W-2:0], cin};
    sum   = prop ^ carry;
    cout  = grp_g[WORD_W-1];
  end

endmodule

// File: rtl/mp_serial_adder.sv
// Multi-precision serial adder, one 32-bit slice per beat, LS word first.
// Define MPADD_SUB_EN to add the in_sub port for A-B operation.
module mp_serial_adder
  import mp_add_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_cin,
`ifdef MPADD_SUB_EN
  input  logic              in_sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_carry,
  output logic              busy
);

  localparam int CNT_W = word_cnt_w(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              last_q, last_d;
  logic              cout_q, cout_d;

  logic              accept;
  logic              is_last;
  logic              sub_now;
  logic [WORD_W-1:0] add_b;
  logic              add_cin;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;

  assign in_ready = !valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign is_last  = (cnt_q == LAST_CNT);

`ifdef MPADD_SUB_EN
  logic sub_q, sub_d;

  assign sub_now = (state_q == IDLE) ? in_sub : sub_q;

  always_comb begin
    sub_d = sub_q;
    if (accept && state_q == IDLE) sub_d = in_sub;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sub_q <= 1'b0;
    else     sub_q <= sub_d;
  end
`else
  assign sub_now = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so the forced word-0 carry replaces in_cin.
  assign add_b   = sub_now ? ~in_b : in_b;
  assign add_cin = (state_q == IDLE) ? (sub_now | in_cin) : carry_q;

  mp_word_adder u_word_adder (
    .a   (in_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    last_d  = last_q;
    cout_d  = cout_q;
    if (accept) begin
      valid_d = 1'b1;
      sum_d   = add_sum;
      last_d  = is_last;
      cout_d  = is_last & add_cout;
      carry_d = add_cout;
      cnt_d   = is_last ? '0 : cnt_q + 1'b1;
      state_d = is_last ? IDLE : RUN;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_last  = last_q;
  assign out_carry = cout_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_mp_serial_adder.sv
// Directed bench for mp_serial_adder with a 129-bit reference model and a
// scoreboard queue; the subtract steps run only when MPADD_SUB_EN is defined.
module tb_mp_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        last;
    logic        carry;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        inCin;
`ifdef MPADD_SUB_EN
  logic        inSub;
`endif
  logic        outValid;
  logic        outReady;
  logic [31:0] outSum;
  logic        outLast;
  logic        outCarry;
  logic        busy;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   fireCount = 0;
  int   lastFireCycle = 0;

  mp_serial_adder #(.NUM_WORDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_a     (inA),
    .in_b     (inB),
    .in_cin   (inCin),
`ifdef MPADD_SUB_EN
    .in_sub   (inSub),
`endif
    .out_valid(outValid),
    .out_ready(outReady),
    .out_sum  (outSum),
    .out_last (outLast),
    .out_carry(outCarry),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [128:0] modelFull(input logic [127:0] a, input logic [127:0] b,
                                             input logic cin, input logic sub);
    logic [128:0] bb;
    logic [128:0] cc;
    bb = {1'b0, (sub ? ~b : b)};
    cc = sub ? 129'd1 : {128'd0, cin};
    return {1'b0, a} + bb + cc;
  endfunction

  // Pop and compare every result word the sink actually takes.
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedOutput", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("outSum", outSum, e.sum);
        checkOutput("outLast", {31'd0, outLast}, {31'd0, e.last});
        checkOutput("outCarry", {31'd0, outCarry}, {31'd0, e.carry});
      end
      fireCount++;
      lastFireCycle = cycle;
    end
  end

  task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b,
                               input logic cin, input logic sub, input int idx);
    logic [128:0] full;
    exp_t e;
    int n;
    full    = modelFull(a, b, cin, sub);
    e.sum   = full[idx*32 +: 32];
    e.last  = (idx == 3);
    e.carry = (idx == 3) ? full[128] : 1'b0;
    inValid = 1'b1;
    inA     = a[idx*32 +: 32];
    inB     = b[idx*32 +: 32];
    inCin   = (idx == 0) ? cin : ~cin;
`ifdef MPADD_SUB_EN
    inSub   = (idx == 0) ? sub : ~sub;
`endif
    n = 0;
    @(negedge clk);
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("inReadyWait", {31'd0, inReady}, 32'd1);
    if (inReady) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic sendTxn(input logic [127:0] a, input logic [127:0] b, input logic cin, input logic sub);
    for (int i = 0; i < 4; i++) applyStimulus(a, b, cin, sub, i);
  endtask

  task automatic waitDrain();
    inValid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !outValid) break;
    end
    checkOutput("drainQueue", 32'(sb.size()), 32'd0);
    checkOutput("outValidDrop", {31'd0, outValid}, 32'd0);
    checkOutput("busyIdle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_inReady"}, {31'd0, inReady}, 32'd1);
    checkOutput({tag, "_outValid"}, {31'd0, outValid}, 32'd0);
    checkOutput({tag, "_outSum"}, outSum, 32'd0);
    checkOutput({tag, "_outLast"}, {31'd0, outLast}, 32'd0);
    checkOutput({tag, "_outCarry"}, {31'd0, outCarry}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    logic [128:0] full;
    int f0;
    int c0;

    rst      = 1'b1;
    inValid  = 1'b0;
    inA      = '0;
    inB      = '0;
    inCin    = 1'b0;
`ifdef MPADD_SUB_EN
    inSub    = 1'b0;
`endif
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Carry ripples through all four words into the final carry-out.
    $display("[TB] all-ones plus one");
    sendTxn({128{1'b1}}, 128'd1, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] carry into word 1 only");
    sendTxn(128'h00000000_00000000_00000001_FFFFFFFF, 128'd1, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] back-to-back transactions");
    a  = 128'h89ABCDEF_01234567_FFFFFFFF_DEADBEEF;
    b  = 128'h76543210_FEDCBA98_00000000_21524110;
    f0 = fireCount;
    c0 = cycle;
    sendTxn(a, b, 1'b0, 1'b0);
    sendTxn(a, b, 1'b1, 1'b0);
    waitDrain();
    checkOutput("b2bFireCount", 32'(fireCount - f0), 32'd8);
    checkOutput("b2bLastFireCycle", 32'(lastFireCycle), 32'(c0 + 8));

    // Stall the sink while word 1 sits in the output register.
    $display("[TB] output stall mid-transaction");
    a    = 128'hFFFFFFFF_FFFFFFFF_12345678_80000000;
    b    = 128'h00000000_00000000_EDCBA988_80000000;
    full = modelFull(a, b, 1'b0, 1'b0);
    applyStimulus(a, b, 1'b0, 1'b0, 0);
    applyStimulus(a, b, 1'b0, 1'b0, 1);
    outReady = 1'b0;
    inA      = 32'hA5A5A5A5;
    inB      = 32'h5A5A5A5A;
    inCin    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stallOutValid", {31'd0, outValid}, 32'd1);
      checkOutput("stallInReady", {31'd0, inReady}, 32'd0);
      checkOutput("stallOutSum", outSum, full[63:32]);
      checkOutput("stallOutLast", {31'd0, outLast}, 32'd0);
      checkOutput("stallBusy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    applyStimulus(a, b, 1'b0, 1'b0, 2);
    applyStimulus(a, b, 1'b0, 1'b0, 3);
    waitDrain();

    // Asynchronous reset after word 1 must drop the partial transaction.
    $display("[TB] reset mid-transaction");
    a = 128'h11111111_22222222_33333333_44444444;
    b = 128'h55555555_66666666_77777777_88888888;
    applyStimulus(a, b, 1'b0, 1'b0, 0);
    applyStimulus(a, b, 1'b0, 1'b0, 1);
    inValid = 1'b0;
    rst     = 1'b1;
    #1;
    checkResetValues("midReset");
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    sendTxn(128'hFFFFFFFF_00000000_FFFFFFFF_FFFFFFFF, 128'h00000000_00000001_00000000_00000000, 1'b1, 1'b0);
    waitDrain();

`ifdef MPADD_SUB_EN
    $display("[TB] subtraction");
    sendTxn(128'd5, 128'd7, 1'b0, 1'b1);
    waitDrain();
    sendTxn(128'd7, 128'd5, 1'b0, 1'b1);
    waitDrain();
    sendTxn(128'd7, 128'd5, 1'b1, 1'b0);
    waitDrain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
